d_operand_unit: RTL

Parametrised decode-stage operand unit: general register file with `NRD` read ports, `NFWD` prioritised forwarding sources plus write-through, and a per-register scoreboard that computes the decode stall from producer Tnew versus consumer Tuse. It sits in the D stage between the F/D pipeline register and the D/E register. It replaces the fixed two-port GRF-plus-mux arrangement, and turns stall detection from per-instruction decode tables into tracked state.

---
 rtl/d_operand_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/d_operand_unit.sv
// Decode-stage operand unit: register file with prioritised forwarding and a
// per-register Tuse/Tnew scoreboard that produces the issue stall.
// Optional writeback trace: define GRF_WB_TRACE_EN.
module d_operand_unit #(
   parameter int unsigned DW   = 32,
   parameter int unsigned NRD  = 2,
   parameter int unsigned NFWD = 2,
   parameter int unsigned TW   = 2,
   parameter int unsigned CW   = 2
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic                Flush,
   input  logic                Iss_Valid,
   output logic                Iss_Ready,
   input  logic [NRD*5-1:0]    Iss_A,
   input  logic [NRD*TW-1:0]   Iss_Tuse,
   input  logic                Iss_Wr,
   input  logic [4:0]          Iss_A3,
   input  logic [TW-1:0]       Iss_Tnew,
   output logic [NRD*DW-1:0]   RD,
   input  logic [NFWD*5-1:0]   Fwd_A3,
   input  logic [NFWD*DW-1:0]  Fwd_WD,
   input  logic [NFWD-1:0]     Fwd_Vld,
   input  logic                W_We,
   input  logic [4:0]          W_A3,
   input  logic [DW-1:0]       W_WD,
   input  logic [31:0]         W_PC
);

   localparam int unsigned NREG = 32;
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   logic [DW-1:0] grf  [NREG];
   logic [CW-1:0] cnt  [NREG];
   logic [TW-1:0] tnew [NREG];

   logic          wb_en;
   logic          acc_en;
   logic          stall;
   logic [4:0]    rd_a;
   logic          rd_hit;
   logic [DW-1:0] rd_val;
   logic [4:0]    st_a;

   assign wb_en  = W_We && (W_A3 != 5'd0);
   assign acc_en = Iss_Valid && Iss_Ready && Iss_Wr && (Iss_A3 != 5'd0);

   // Operand read: $0, then youngest matching forward source, then write-through, then array
   always_comb begin
      RD     = '0;
      rd_a   = '0;
      rd_hit = 1'b0;
      rd_val = '0;
      for (int unsigned i = 0; i < NRD; i++) begin
         rd_a   = Iss_A[5*i +: 5];
         rd_hit = 1'b0;
         rd_val = '0;
         if (rd_a != 5'd0) begin
            for (int unsigned j = 0; j < NFWD; j++) begin
               if (!rd_hit && Fwd_Vld[j] && (Fwd_A3[5*j +: 5] == rd_a)) begin
                  rd_hit = 1'b1;
                  rd_val = Fwd_WD[DW*j +: DW];
               end
            end
            if (!rd_hit) begin
               if (wb_en && (W_A3 == rd_a)) rd_val = W_WD;
               else                         rd_val = grf[rd_a];
            end
         end
         RD[DW*i +: DW] = rd_val;
      end
   end

   // Stall when a pending producer is too late for a consumer, or the writer counter is full
   always_comb begin
      stall = 1'b0;
      st_a  = '0;
      for (int unsigned i = 0; i < NRD; i++) begin
         st_a = Iss_A[5*i +: 5];
         if ((st_a != 5'd0) && (cnt[st_a] != '0) && (tnew[st_a] > Iss_Tuse[TW*i +: TW]))
            stall = 1'b1;
      end
      if (Iss_Wr && (cnt[Iss_A3] == CNT_MAX))
         stall = 1'b1;
   end

   assign Iss_Ready = !stall;

   // Register array and scoreboard update
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int unsigned r = 0; r < NREG; r++) begin
            grf[r]  <= '0;
            cnt[r]  <= '0;
            tnew[r] <= '0;
         end
      end else begin
         if (wb_en) grf[W_A3] <= W_WD;
         for (int unsigned r = 1; r < NREG; r++) begin
            if (Flush) begin
               cnt[r]  <= '0;
               tnew[r] <= '0;
            end else begin
               // Accept and writeback on the same register cancel in the counter
               if (acc_en && (Iss_A3 == 5'(r)) && !(wb_en && (W_A3 == 5'(r))))
                  cnt[r] <= cnt[r] + CW'(1);
               else if (!(acc_en && (Iss_A3 == 5'(r))) && wb_en && (W_A3 == 5'(r))
                        && (cnt[r] != '0))
                  cnt[r] <= cnt[r] - CW'(1);
               if (acc_en && (Iss_A3 == 5'(r)))
                  tnew[r] <= Iss_Tnew;
               else if (tnew[r] != '0)
                  tnew[r] <= tnew[r] - TW'(1);
            end
         end
      end
   end

`ifdef GRF_WB_TRACE_EN
   // Writeback trace line at the clock edge
   always_ff @(posedge Clk) begin
      if (Rst_n && wb_en)
         $display("@%h: $%0d <= %h", W_PC, W_A3, W_WD);
   end
`else
   logic unused_pc;
   assign unused_pc = ^W_PC;
`endif

endmodule
